// File: rtl/bcd_to_bin_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_to_bin_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CONV = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd8;
  localparam logic [DIGIT_W-1:0] ADJ_SUB    = 4'd3;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX  = 4'd9;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_adj.sv
// Per-digit correction applied after each right shift: a digit >= 8 loses 3.
module bcd_digit_adj
  import bcd_to_bin_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= ADJ_THRESH) ? (digit_i - ADJ_SUB) : digit_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// Optional input digit range check is enabled by defining BCD_TO_BIN_CHECK_EN.
//
// state  | meaning
// S_IDLE | waiting for start; bin/err hold last result
// S_LOAD | operand captured; digit check runs here
// S_CONV | one shift-and-adjust per cycle, BIN_W cycles
// S_DONE | one-cycle done pulse
module bcd_to_bin_seq
  import bcd_to_bin_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic [DIGIT_W*DIGITS-1:0] bcd_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [BIN_W-1:0]        bin_o,
  output logic                    err_o
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_e           state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             err_q, err_d;

  logic [SR_W-1:0]  shifted;
  logic [BCD_W-1:0] adj_bcd;
  logic [SR_W-1:0]  sr_conv;
  logic             digit_bad;

  // Bits leaving the BCD LSB fall straight into the binary MSB.
  assign shifted = {1'b0, sr_q[SR_W-1:1]};

  genvar g;
  for (g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (shifted[BIN_W + g*DIGIT_W +: DIGIT_W]),
      .digit_o (adj_bcd[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign sr_conv = {adj_bcd, shifted[BIN_W-1:0]};

`ifdef BCD_TO_BIN_CHECK_EN
  always_comb begin
    digit_bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr_q[BIN_W + d*DIGIT_W +: DIGIT_W] > DIGIT_MAX) digit_bad = 1'b1;
    end
  end
`else
  assign digit_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sr_d    = {bcd_i, {BIN_W{1'b0}}};
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (digit_bad) begin
          err_d   = 1'b1;
          bin_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        sr_d  = sr_conv;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          bin_d   = sr_conv[BIN_W-1:0];
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign busy_o = (state_q == S_LOAD) || (state_q == S_CONV);
  assign done_o = (state_q == S_DONE);
  assign bin_o  = bin_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: vector table, full sweep and corner sequences.
module tb_bcd_to_bin_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] bcd;
  logic       busy, done, err;
  logic [6:0] bin;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [6:0] bin;
    logic       err;
  } exp_t;

  typedef struct {
    logic [7:0] bcd;
    logic [6:0] bin;
    logic       err;
  } vec_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (start),
    .bcd_i   (bcd),
    .busy_o  (busy),
    .done_o  (done),
    .bin_o   (bin),
    .err_o   (err)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Pulses start for one cycle and waits (bounded) for done; inputs change on negedges.
  task automatic convert(input logic [7:0] b, input logic [6:0] eb, input logic ee,
                         input int exp_lat, input int exp_busy);
    int   cycles;
    int   busy_cnt;
    exp_t e;
    sb_q.push_back('{bin: eb, err: ee});
    bcd   = b;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    cycles   = 1;
    busy_cnt = 0;
    while (!done && cycles < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    chk($sformatf("latency bcd=%h", b), cycles, exp_lat);
    chk($sformatf("busy_cycles bcd=%h", b), busy_cnt, exp_busy);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk($sformatf("bin bcd=%h", b), int'(bin), int'(e.bin));
      chk($sformatf("err bcd=%h", b), int'(err), int'(e.err));
    end
    @(negedge clk);
    chk($sformatf("done_one_cycle bcd=%h", b), int'(done), 0);
  endtask

  initial begin
    vec_t vecs[5];
    int   dones;
    int   first_done;
    int   second_done;
    logic [3:0] t4, o4;

    vecs[0] = '{bcd: 8'h10, bin: 7'd10, err: 1'b0};
    vecs[1] = '{bcd: 8'h00, bin: 7'd0,  err: 1'b0};
    vecs[2] = '{bcd: 8'h07, bin: 7'd7,  err: 1'b0};
    vecs[3] = '{bcd: 8'h42, bin: 7'd42, err: 1'b0};
    vecs[4] = '{bcd: 8'h99, bin: 7'd99, err: 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    bcd   = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // idle after reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_idle_outputs", int'({busy, done, bin, err}), 0);
    end

    for (int i = 0; i < 5; i++)
      convert(vecs[i].bcd, vecs[i].bin, vecs[i].err, 9, 8);

    for (int t = 0; t < 10; t++) begin
      for (int o = 0; o < 10; o++) begin
        t4 = 4'(t);
        o4 = 4'(o);
        convert({t4, o4}, 7'(t * 10 + o), 1'b0, 9, 8);
      end
    end

    // start re-pulsed mid-conversion is ignored
    sb_q.push_back('{bin: 7'd27, err: 1'b0});
    bcd = 8'h27; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    bcd = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) begin
        dones++;
        if (sb_q.size() > 0) chk("ignored_start_bin", int'(bin), int'(sb_q.pop_front().bin));
      end
      @(negedge clk);
    end
    chk("ignored_start_done_count", dones, 1);
    chk("scoreboard_empty", sb_q.size(), 0);

    // start held high: back-to-back conversions, next accepted right after done
    bcd = 8'h33; start = 1'b1;
    first_done = -1; second_done = -1;
    for (int i = 1; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        if (first_done < 0) first_done = i;
        else if (second_done < 0) second_done = i;
        chk("held_start_bin", int'(bin), 33);
      end
    end
    start = 1'b0;
    chk("held_start_first_latency", first_done, 9);
    chk("held_start_gap", second_done - first_done, 10);
    repeat (12) @(negedge clk);

`ifdef BCD_TO_BIN_CHECK_EN
    convert(8'h3A, 7'd0, 1'b1, 2, 1);
    convert(8'h12, 7'd12, 1'b0, 9, 8);
    convert(8'hF0, 7'd0, 1'b1, 2, 1);
`endif

    // reset during the 4th conversion cycle aborts everything
    bcd = 8'h64; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero", int'({busy, done, bin, err}), 0);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_bin_stays_zero", int'(bin), 0);
    convert(8'h64, 7'd64, 1'b0, 9, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
